// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that shares one memory port between NUM_PORTS requestors.
// Optional watchdog abort of stalled accesses is enabled by defining ARB_WATCHDOG_EN.
module mem_arbiter_rr #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned MASK_WIDTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned ID_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_wmask,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic                             req_err,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic [MASK_WIDTH-1:0]            mem_byte_enable,
    input  logic                             mem_resp,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [ID_W-1:0]                  grant_id,
    output logic                             busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] mask_q, mask_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;

    logic [NUM_PORTS-1:0]  req_any;
    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic [ID_W-1:0]       scan_id;
    logic [ID_W-1:0]       next_ptr;
    logic                  timeout;
    logic                  done;

    logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];
    logic [MASK_WIDTH-1:0] mask_a  [NUM_PORTS];

    // Split the packed per-port request buses into indexable arrays.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr_a[g]  = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign mask_a[g]  = req_wmask[g*MASK_WIDTH +: MASK_WIDTH];
    end

    assign req_any = req_read | req_write;

    // First requesting port at or after the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_id   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_id = ID_W'((32'(ptr_q) + i) % NUM_PORTS);
            if (!win_found && req_any[scan_id]) begin
                win_found = 1'b1;
                win_id    = scan_id;
            end
        end
    end

    assign next_ptr = (grant_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_q + ID_W'(1);

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] wd_q, wd_d;

    // Counter is held at zero in IDLE so each access starts from a clean count.
    always_comb begin
        wd_d = '0;
        if (state_q == ST_ACCESS && !mem_resp) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout = (state_q == ST_ACCESS) && (wd_q == WD_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    assign done = mem_resp || timeout;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_ACCESS;
                    grant_d = win_id;
                    addr_d  = addr_a[win_id];
                    wdata_d = wdata_a[win_id];
                    mask_d  = mask_a[win_id];
                    wr_d    = req_write[win_id];
                    rd_d    = !req_write[win_id];
                end
            end
            ST_ACCESS: begin
                if (done) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Completion pulse is combinational so the owner sees it in the mem_resp cycle.
    always_comb begin
        req_resp = '0;
        req_err  = 1'b0;
        if (state_q == ST_ACCESS && done && !rst) begin
            req_resp[grant_q] = 1'b1;
            req_err           = !mem_resp;
        end
    end

    assign req_rdata       = mem_rdata;
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = mask_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q == ST_ACCESS);

endmodule
